clock_divider_ctrl: RTL and testbench
=====================================

// Module: clock_divider_ctrl
// PURPOSE
//   Runtime-programmable clock divider controller. Generates a 50%-duty divided clock whose
//   half-period is set over a valid/ready config port. Ratio changes and start/stop happen only
//   at phase boundaries, so clk_out never carries a runt pulse.
//   Sits between the system control logic and every consumer of a slow divided clock/strobe.
// PARAMETERS
//   CNT_W         8   width of half-period value and phase counter
//   DEFAULT_HALF  3   half-period loaded at reset (3 -> divide-by-6); must be 1..2^CNT_W-1
// PORTS
//   clk        in   1      system clock, all logic on posedge
//   reset      in   1      synchronous, active-high reset
//   en         in   1      level: 1 = run divided clock, 0 = stop (glitch-free)
//   cfg_valid  in   1      config request valid
//   cfg_half   in   CNT_W  requested half-period in clk cycles; 0 is illegal
//   cfg_ready  out  1      controller can accept a config (combinational from state)
//   cfg_err    out  1      one-cycle pulse: accepted request had cfg_half==0, ignored
//   clk_out    out  1      divided clock, registered; high and low phases each cur_half cycles
//   rise_tick  out  1      one-cycle pulse in the same cycle clk_out first reads 1
//   cur_half   out  CNT_W  half-period currently in force
//   running    out  1      1 in RUN/PEND/STOP
// BEHAVIOUR
//   Reset (sync, wins over everything): state=IDLE, cnt=0, clk_out=0, rise_tick=0, cfg_err=0,
//     cur_half=DEFAULT_HALF, pending discarded; cfg_ready=1, running=0 next cycle.
//   Transfer = cfg_valid & cfg_ready. cfg_half==0 -> cfg_err=1 next cycle, no other effect.
//   States:
//     IDLE: clk_out=0, cnt=0. Legal transfer -> cur_half<=cfg_half. en=1 -> RUN, cnt<=0;
//           a transfer in that same cycle governs the first low phase. cfg_ready=1.
//     RUN:  cnt increments; at cnt==cur_half-1: cnt<=0, clk_out toggles. First rise occurs
//           cur_half cycles after RUN entry; period = 2*cur_half. cfg_ready=1.
//           Legal transfer -> pend<=cfg_half, go PEND. en=0 -> STOP if clk_out=1, IDLE if 0.
//           Transfer and en=0 in same cycle: store pend, then act as en=0 (pend kept).
//     PEND: counts as RUN with old cur_half; cfg_ready=0. At end of a LOW phase
//           (cnt==cur_half-1 & clk_out=0): cur_half<=pend, cnt<=0, clk_out<=1 -> RUN.
//           New ratio always starts with a full high phase. en=0 handled as in RUN.
//     STOP: cfg_ready=0; finishes current high phase; at cnt==cur_half-1: clk_out<=0, cnt<=0,
//           -> IDLE. Any held pend is written to cur_half on IDLE entry.
//           en=1 during STOP is ignored until IDLE is reached.
//   cur_half=1: clk_out toggles every clk (divide-by-2); rise_tick every 2nd cycle.
//   cnt never exceeds cur_half-1, so CNT_W bits never wrap; no saturation logic needed.
//   Outputs all registered except cfg_ready, running (decode of state register).
// STRUCTURE
//   Shared package/include clk_div_pkg: state encoding (IDLE/RUN/PEND/STOP, 2 bits),
//     CNT_W default, DEFAULT_HALF default.
//   Sub-module half_period_counter: cnt register, load/clear/enable, terminal flag
//     (cnt==limit-1). FSM, pend register, handshake and clk_out toggle stay in this module.
// TESTING
//   1 reset, en=1 held, defaults -> first clk_out rise 3 cycles after RUN entry, period 6,
//     rise_tick once per period, cur_half=3, running=1.
//   2 RUN, clk_out high, cfg_half=5 -> cfg_ready=0 until current low phase (3) ends, then
//     high 5 / low 5, cur_half=5, cfg_ready=1.
//   3 RUN, cfg_half=0 transfer -> cfg_err high exactly 1 cycle, cur_half stays 3, clocking
//     undisturbed.
//   4 en=0 one cycle after a rise (half=3) -> clk_out stays high 2 more cycles, falls, IDLE,
//     running=0; no high pulse shorter than 3 cycles anywhere.
//   5 reset asserted while in PEND -> next cycle clk_out=0, cur_half=3, cfg_ready=1, no apply.
//   6 IDLE, en=1 and cfg_half=1 same cycle -> clk_out toggles every cycle, first rise 1 cycle
//     after RUN entry.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the runtime-programmable clock divider:
// controller state encoding and default widths/ratios.
package clk_div_pkg;

  // Width of the half-period value and of the phase counter.
  localparam int CNT_W_DEF = 8;

  // Half-period loaded at reset (3 -> divide-by-6).
  localparam int unsigned DEFAULT_HALF_DEF = 3;

  // Controller states.
  //   IDLE : clock parked low, counter cleared
  //   RUN  : free-running divided clock
  //   PEND : running with a new ratio waiting for the end of a low phase
  //   STOP : finishing the current high phase before parking low
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_STOP = 2'd3
  } state_e;

endpackage

// File: rtl/half_period_counter.sv
// Phase counter for the clock divider. Counts 0..limit-1 and wraps;
// term flags the last cycle of a phase so the controller can toggle
// the divided clock on that same edge.
module half_period_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,    // force count back to 0 (parks the phase)
  input  logic             inc,    // advance one cycle
  input  logic [CNT_W-1:0] limit,  // half-period in force, never 0
  output logic [CNT_W-1:0] cnt,
  output logic             term    // cnt == limit-1
);

  // limit is guaranteed non-zero by the controller, so limit-1 never
  // underflows and cnt never exceeds limit-1.
  assign term = (cnt == (limit - CNT_W'(1)));

  // Count register: clear has priority, wrap to 0 at the terminal count.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= term ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Runtime-programmable clock divider controller. Produces a 50%-duty
// divided clock whose half-period is set over a valid/ready port.
// Ratio changes and start/stop only take effect on phase boundaries
// so clk_out never carries a runt pulse.
module clock_divider_ctrl
  import clk_div_pkg::*;
#(
  parameter int          CNT_W        = CNT_W_DEF,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_tick,
  output logic [CNT_W-1:0] cur_half,
  output logic             running
);

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  state_e           state;
  logic [CNT_W-1:0] pend;
  logic             pend_vld;

  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             cnt_clr;
  logic             cnt_inc;

  logic             xfer;
  logic             xfer_ok;
  logic [CNT_W-1:0] pend_nxt;
  logic             pend_vld_nxt;

  // Config is only accepted while the current ratio can be replaced
  // without an outstanding pending value.
  assign cfg_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign running   = (state != ST_IDLE);

  assign xfer      = cfg_valid && cfg_ready;
  assign xfer_ok   = xfer && (cfg_half != '0);

  // Pending ratio as it will stand after this cycle's transfer; used when
  // a transfer and en=0 coincide so the new ratio survives into IDLE.
  always_comb begin
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
    if (xfer_ok) begin
      pend_nxt     = cfg_half;
      pend_vld_nxt = 1'b1;
    end
  end

  // Counter control: parked at 0 in IDLE, and cleared when a low phase is
  // abandoned by en=0. Phase ends inside STOP/PEND rely on the wrap at term.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = (state != ST_IDLE);
    if (state == ST_IDLE) begin
      cnt_clr = 1'b1;
    end else if ((state == ST_RUN || state == ST_PEND) && !en && !clk_out) begin
      cnt_clr = 1'b1;
    end
  end

  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cur_half),
    .cnt   (cnt),
    .term  (term)
  );

  // Controller FSM with registered clock, tick, error and ratio outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      cfg_err   <= 1'b0;
      cur_half  <= HALF_RST;
      pend      <= '0;
      pend_vld  <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      cfg_err   <= xfer && (cfg_half == '0);

      unique case (state)
        ST_IDLE: begin
          clk_out <= 1'b0;
          // A transfer in the same cycle as en=1 sets the first low phase.
          if (xfer_ok) cur_half <= cfg_half;
          if (en) state <= ST_RUN;
        end

        ST_RUN, ST_PEND: begin
          pend     <= pend_nxt;
          pend_vld <= pend_vld_nxt;
          if (!en) begin
            if (clk_out && !term) begin
              // Let the high phase run to completion.
              state <= ST_STOP;
            end else begin
              // Low phase, or the high phase ends right now: park low.
              clk_out  <= 1'b0;
              state    <= ST_IDLE;
              pend_vld <= 1'b0;
              if (pend_vld_nxt) cur_half <= pend_nxt;
            end
          end else if (state == ST_PEND && term && !clk_out) begin
            // New ratio always begins with a full high phase.
            cur_half  <= pend;
            pend_vld  <= 1'b0;
            clk_out   <= 1'b1;
            rise_tick <= 1'b1;
            state     <= ST_RUN;
          end else begin
            if (term) begin
              clk_out   <= ~clk_out;
              rise_tick <= ~clk_out;
            end
            if (xfer_ok) state <= ST_PEND;
          end
        end

        ST_STOP: begin
          // en is ignored here; finish the high phase and park.
          if (term) begin
            clk_out  <= 1'b0;
            state    <= ST_IDLE;
            pend_vld <= 1'b0;
            if (pend_vld) cur_half <= pend;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: a table of per-cycle
// {inputs, expected outputs} rows plus hand-written long-period and
// IDLE error sequences.
module tb_clock_divider_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_half;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       rise_tick;
  logic [7:0] cur_half;
  logic       running;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_divider_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .cur_half  (cur_half),
    .running   (running)
  );

  // exp = {clk_out, rise_tick, cfg_ready, running, cfg_err, cur_half}
  typedef struct {
    logic        rst;
    logic        en;
    logic        v;
    logic [7:0]  half;
    logic [12:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic e, input logic v,
                              input logic [7:0] h, input logic co, input logic rt,
                              input logic rdy, input logic run, input logic err,
                              input logic [7:0] cur);
    vec_t r;
    r.rst  = rst;
    r.en   = e;
    r.v    = v;
    r.half = h;
    r.exp  = {co, rt, rdy, run, err, cur};
    return r;
  endfunction

  function automatic logic [12:0] obs();
    return {clk_out, rise_tick, cfg_ready, running, cfg_err, cur_half};
  endfunction

  task automatic step(input logic rst, input logic e, input logic v, input logic [7:0] h);
    reset     = rst;
    en        = e;
    cfg_valid = v;
    cfg_half  = h;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin
    int n;
    int m;

    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;

    //                 rst en v half   co rt rdy run err cur
    // reset, then en=1 with default ratio 3: rise 3 cycles in, period 6
    vq.push_back(mk(1, 0, 0, 0,    0, 0, 1, 0, 0, 3));  // 0 reset
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));  // 1 RUN entry
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 3));  // 4 first rise
    vq.push_back(mk(0, 1, 0, 0,    1, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));  // 7 fall
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 3));  // 10 rise, period 6
    // illegal half=0 transfer: one-cycle cfg_err, nothing else moves
    vq.push_back(mk(0, 1, 1, 0,    1, 0, 1, 1, 1, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 3));  // 16 rise
    // en=0 one cycle after rise: high phase completes, en=1 in STOP ignored
    vq.push_back(mk(0, 0, 0, 0,    1, 0, 0, 1, 0, 3));  // STOP
    vq.push_back(mk(0, 1, 0, 0,    1, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 0, 0, 3));  // 19 IDLE
    vq.push_back(mk(0, 0, 0, 0,    0, 0, 1, 0, 0, 3));
    // half=5 requested while high: applied only after the low phase ends
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));  // 21 RUN entry
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 3));  // 24 rise
    vq.push_back(mk(0, 1, 1, 5,    1, 0, 0, 1, 0, 3));  // PEND
    vq.push_back(mk(0, 1, 0, 0,    1, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 0, 1, 0, 3));  // 27 fall
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 5));  // 30 apply, high 5
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1, 0, 0, 1, 0, 1, 1, 0, 5));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 5));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 5));  // 40 rise after low 5
    // reset during PEND discards the pending ratio
    vq.push_back(mk(0, 1, 1, 7,    1, 0, 0, 1, 0, 5));  // PEND
    vq.push_back(mk(1, 1, 0, 0,    0, 0, 1, 0, 0, 3));  // reset
    vq.push_back(mk(0, 0, 0, 0,    0, 0, 1, 0, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));  // RUN entry
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 3));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 3));  // rise, ratio still 3
    vq.push_back(mk(0, 0, 0, 0,    1, 0, 0, 1, 0, 3));  // STOP
    vq.push_back(mk(0, 0, 0, 0,    1, 0, 0, 1, 0, 3));
    vq.push_back(mk(0, 0, 0, 0,    0, 0, 1, 0, 0, 3));  // IDLE
    // en=1 with half=1 same cycle: divide-by-2, first rise 1 cycle in
    vq.push_back(mk(0, 1, 1, 1,    0, 0, 1, 1, 0, 1));  // RUN entry
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 1));
    // transfer and en=0 together while low: new ratio held into IDLE
    vq.push_back(mk(0, 0, 1, 4,    0, 0, 1, 0, 0, 4));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 4));  // RUN entry
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 4));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 4));
    vq.push_back(mk(0, 1, 0, 0,    0, 0, 1, 1, 0, 4));
    vq.push_back(mk(0, 1, 0, 0,    1, 1, 1, 1, 0, 4));  // rise 4 cycles in

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].en, vq[i].v, vq[i].half);
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
    end

    // IDLE corner cases: illegal request flags error, max ratio 255
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    check("idle_err", 32'({cfg_err, cur_half}), 32'({1'b1, 8'd3}));
    step(0, 0, 1, 8'd255);
    check("idle_load", 32'({cfg_err, running, cur_half}), 32'({1'b0, 1'b0, 8'd255}));
    step(0, 1, 0, 0);  // RUN entry
    n = 0;
    while (!clk_out && n < 600) begin
      step(0, 1, 0, 0);
      n++;
    end
    check("max_first_rise", 32'(n), 32'd255);
    check("max_rise_tick", 32'(rise_tick), 32'd1);
    m = 0;
    while (clk_out && m < 600) begin
      step(0, 1, 0, 0);
      m++;
    end
    check("max_high_len", 32'(m), 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
